namco_ctrl_regs: RTL and testbench

NAMCO_CTRL_REGS -- requirements
Module: namco_ctrl_regs

---
 rtl/namco_regs_pkg.sv | 32 +++
 rtl/namco_irq_gen.sv | 61 ++++++
 rtl/namco_ctrl_regs.sv | 181 ++++++++++++++++++
 tb/tb_namco_ctrl_regs.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/namco_regs_pkg.sv
// Shared constants and types for the Namco-style control latch block:
// default bus addresses, IRQ mode/state enums and a ceil-log2 helper.
package namco_regs_pkg;

    localparam logic [15:0] DEF_MBASE   = 16'h5000;
    localparam logic [15:0] DEF_SBASE   = 16'h2000;
    localparam logic [15:0] DEF_SCRBASE = 16'h3800;
    localparam logic [15:0] DEF_WDBASE  = 16'h8000;

    typedef enum logic {
        IRQ_LEVEL   = 1'b0,
        IRQ_LATCHED = 1'b1
    } irq_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } irq_state_e;

    // Number of address bits needed to index n latches (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/namco_irq_gen.sv
// One IRQ channel: either the enable gated by the synchronised VBLANK level,
// or a pending flag set on a VBLANK rising edge and cleared by a disable write.
module namco_irq_gen
    import namco_regs_pkg::*;
#(
    parameter irq_mode_e MODE = IRQ_LEVEL
)(
    input  logic clk_i,
    input  logic rst_i,
    input  logic vb_s_i,
    input  logic vb_rise_i,
    input  logic en_i,
    input  logic clr_i,
    output logic irq_o
);

    irq_state_e state_q;
    irq_state_e state_d;

    // Pending-state register, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a disable write beats a coincident VBLANK edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (vb_rise_i && en_i && !clr_i) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (clr_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IRQ output selected by the elaboration-time mode.
    always_comb begin
        irq_o = 1'b0;
        if (MODE == IRQ_LATCHED) begin
            irq_o = (state_q == ST_PEND);
        end else begin
            irq_o = en_i & vb_s_i;
        end
    end

endmodule

// File: rtl/namco_ctrl_regs.sv
// Control latches, scroll register and VBLANK IRQs shared by a main and a sub CPU.
// Latch value comes from A[0], latch index from A[L:1]. Optional watchdog
// is compiled in with the macro NAMCO_CTRL_REGS_WDOG_EN.
module namco_ctrl_regs
    import namco_regs_pkg::*;
#(
    parameter int          NLATCH   = 8,
    parameter logic [15:0] MBASE    = DEF_MBASE,
    parameter logic [15:0] SBASE    = DEF_SBASE,
    parameter logic [15:0] SWMASK   = 16'h002B,
    parameter int          SCRW     = 8,
    parameter logic [15:0] SCRBASE  = DEF_SCRBASE,
    parameter irq_mode_e   IRQ_MODE = IRQ_LEVEL,
    parameter int          MIRQ_IDX = 1,
    parameter int          SIRQ_IDX = 0
`ifdef NAMCO_CTRL_REGS_WDOG_EN
    ,
    parameter logic [15:0] WDBASE   = DEF_WDBASE,
    parameter int          WDLIMIT  = 8
`endif
)(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [15:0]       MCPU_ADRS,
    input  logic              MCPU_VMA,
    input  logic              MCPU_WE,
    input  logic [15:0]       SCPU_ADRS,
    input  logic              SCPU_VMA,
    input  logic              SCPU_WE,
    input  logic              VBLANK,
    output logic [NLATCH-1:0] LATCH,
    output logic [SCRW-1:0]   SCROLL,
    output logic              MCPU_IRQ,
    output logic              SCPU_IRQ
`ifdef NAMCO_CTRL_REGS_WDOG_EN
    ,
    output logic              WDOG_RST
`endif
);

    localparam int L = clog2(NLATCH);

    logic [NLATCH-1:0] latch_q, latch_d;
    logic [NLATCH-1:0] wr0_s, m_wr_s, s_wr_s;
    logic [SCRW-1:0]   scroll_q, scroll_d;
    logic              vb_meta_q, vb_s_q, vb_prev_q, vb_rise_s;
    logic              m_hit_s, s_hit_s, scr_hit_s;
    logic [L-1:0]      m_idx_s, s_idx_s;

    assign m_hit_s   = MCPU_VMA & MCPU_WE & (MCPU_ADRS[15:L+1] == MBASE[15:L+1]);
    assign s_hit_s   = SCPU_VMA & SCPU_WE & (SCPU_ADRS[15:L+1] == SBASE[15:L+1]);
    assign scr_hit_s = MCPU_VMA & MCPU_WE & (MCPU_ADRS[15:11] == SCRBASE[15:11]);
    assign m_idx_s   = MCPU_ADRS[L:1];
    assign s_idx_s   = SCPU_ADRS[L:1];
    assign vb_rise_s = vb_s_q & ~vb_prev_q;

    // Resolve main/sub latch writes; sub wins on the same index, and flag
    // every accepted write of 0 so the latched IRQ channels can clear.
    always_comb begin
        latch_d = latch_q;
        wr0_s   = {NLATCH{1'b0}};
        m_wr_s  = {NLATCH{1'b0}};
        s_wr_s  = {NLATCH{1'b0}};
        for (int i = 0; i < NLATCH; i++) begin
            m_wr_s[i] = m_hit_s && (m_idx_s == L'(i));
            s_wr_s[i] = s_hit_s && (s_idx_s == L'(i)) && SWMASK[i];
            if (s_wr_s[i]) begin
                latch_d[i] = SCPU_ADRS[0];
                wr0_s[i]   = ~SCPU_ADRS[0];
            end else if (m_wr_s[i]) begin
                latch_d[i] = MCPU_ADRS[0];
                wr0_s[i]   = ~MCPU_ADRS[0];
            end else begin
                latch_d[i] = latch_q[i];
            end
        end
    end

    // Scroll register loads from the main-CPU address inside its window.
    always_comb begin
        if (scr_hit_s) begin
            scroll_d = MCPU_ADRS[SCRW+2:3];
        end else begin
            scroll_d = scroll_q;
        end
    end

    // Latch, scroll and VBLANK synchroniser/edge-history flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            latch_q   <= {NLATCH{1'b0}};
            scroll_q  <= {SCRW{1'b0}};
            vb_meta_q <= 1'b0;
            vb_s_q    <= 1'b0;
            vb_prev_q <= 1'b0;
        end else begin
            latch_q   <= latch_d;
            scroll_q  <= scroll_d;
            vb_meta_q <= VBLANK;
            vb_s_q    <= vb_meta_q;
            vb_prev_q <= vb_s_q;
        end
    end

    assign LATCH  = latch_q;
    assign SCROLL = scroll_q;

    namco_irq_gen #(.MODE(IRQ_MODE)) u_mirq (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .vb_s_i    (vb_s_q),
        .vb_rise_i (vb_rise_s),
        .en_i      (latch_q[MIRQ_IDX]),
        .clr_i     (wr0_s[MIRQ_IDX]),
        .irq_o     (MCPU_IRQ)
    );

    namco_irq_gen #(.MODE(IRQ_MODE)) u_sirq (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .vb_s_i    (vb_s_q),
        .vb_rise_i (vb_rise_s),
        .en_i      (latch_q[SIRQ_IDX]),
        .clr_i     (wr0_s[SIRQ_IDX]),
        .irq_o     (SCPU_IRQ)
    );

`ifdef NAMCO_CTRL_REGS_WDOG_EN
    logic [3:0] wd_cnt_q, wd_cnt_d;
    logic       wd_act_q, wd_act_d;
    logic [4:0] wd_len_q, wd_len_d;
    logic       wd_kick_s, wd_end_s;

    assign wd_kick_s = MCPU_VMA & MCPU_WE & (MCPU_ADRS == WDBASE);
    assign wd_end_s  = wd_act_q & (wd_len_q == 5'd1);

    // Watchdog: saturating VBLANK-edge counter and a 16-cycle reset pulse
    // that a kick cannot shorten; the counter clears when the pulse ends.
    always_comb begin
        wd_act_d = wd_act_q;
        wd_len_d = wd_len_q;
        if (wd_act_q) begin
            if (wd_end_s) begin
                wd_act_d = 1'b0;
                wd_len_d = 5'd0;
            end else begin
                wd_len_d = wd_len_q - 5'd1;
            end
        end else if (wd_cnt_q >= 4'(WDLIMIT)) begin
            wd_act_d = 1'b1;
            wd_len_d = 5'd16;
        end else begin
            wd_len_d = 5'd0;
        end

        if (wd_end_s || wd_kick_s) begin
            wd_cnt_d = 4'd0;
        end else if (vb_rise_s && (wd_cnt_q != 4'hF)) begin
            wd_cnt_d = wd_cnt_q + 4'd1;
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
    end

    // Watchdog state flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt_q <= 4'd0;
            wd_act_q <= 1'b0;
            wd_len_q <= 5'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_act_q <= wd_act_d;
            wd_len_q <= wd_len_d;
        end
    end

    assign WDOG_RST = wd_act_q;
`endif

endmodule

// File: tb/tb_namco_ctrl_regs.sv
// Directed bench for namco_ctrl_regs: one level-mode and one latched-mode
// instance share the same bus and VBLANK stimulus.
module tb_namco_ctrl_regs;
    import namco_regs_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m_adrs = 16'h0000;
    logic        m_vma = 1'b0, m_we = 1'b0;
    logic [15:0] s_adrs = 16'h0000;
    logic        s_vma = 1'b0, s_we = 1'b0;
    logic        vblank = 1'b0;

    logic [7:0] latch_a, latch_b, scroll_a, scroll_b;
    logic       mirq_a, sirq_a, mirq_b, sirq_b;
`ifdef NAMCO_CTRL_REGS_WDOG_EN
    logic       wdog_a, wdog_b;
    int         wd_hi = 0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    namco_ctrl_regs dut_a (
        .CLK(clk), .RESET(rst),
        .MCPU_ADRS(m_adrs), .MCPU_VMA(m_vma), .MCPU_WE(m_we),
        .SCPU_ADRS(s_adrs), .SCPU_VMA(s_vma), .SCPU_WE(s_we),
        .VBLANK(vblank),
        .LATCH(latch_a), .SCROLL(scroll_a), .MCPU_IRQ(mirq_a), .SCPU_IRQ(sirq_a)
`ifdef NAMCO_CTRL_REGS_WDOG_EN
        , .WDOG_RST(wdog_a)
`endif
    );

    namco_ctrl_regs #(.IRQ_MODE(IRQ_LATCHED)) dut_b (
        .CLK(clk), .RESET(rst),
        .MCPU_ADRS(m_adrs), .MCPU_VMA(m_vma), .MCPU_WE(m_we),
        .SCPU_ADRS(s_adrs), .SCPU_VMA(s_vma), .SCPU_WE(s_we),
        .VBLANK(vblank),
        .LATCH(latch_b), .SCROLL(scroll_b), .MCPU_IRQ(mirq_b), .SCPU_IRQ(sirq_b)
`ifdef NAMCO_CTRL_REGS_WDOG_EN
        , .WDOG_RST(wdog_b)
`endif
    );

`ifdef NAMCO_CTRL_REGS_WDOG_EN
    always @(negedge clk) begin
        if (wdog_a === 1'b1) wd_hi = wd_hi + 1;
    end
`endif

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mwr(input logic [15:0] a);
        m_adrs = a; m_vma = 1'b1; m_we = 1'b1;
        cyc(1);
        m_vma = 1'b0; m_we = 1'b0;
    endtask

    task automatic swr(input logic [15:0] a);
        s_adrs = a; s_vma = 1'b1; s_we = 1'b1;
        cyc(1);
        s_vma = 1'b0; s_we = 1'b0;
    endtask

    task automatic bwr(input logic [15:0] ma, input logic [15:0] sa);
        m_adrs = ma; m_vma = 1'b1; m_we = 1'b1;
        s_adrs = sa; s_vma = 1'b1; s_we = 1'b1;
        cyc(1);
        m_vma = 1'b0; m_we = 1'b0; s_vma = 1'b0; s_we = 1'b0;
    endtask

    task automatic test_reset;
        cyc(2);
        n_chk++; if (latch_a !== 8'h00 || latch_b !== 8'h00) begin n_fail++; $display("FAIL reset_latch: got %h/%h expected 00", latch_a, latch_b); end
        n_chk++; if (scroll_a !== 8'h00 || scroll_b !== 8'h00) begin n_fail++; $display("FAIL reset_scroll: got %h/%h expected 00", scroll_a, scroll_b); end
        n_chk++; if ({mirq_a, sirq_a, mirq_b, sirq_b} !== 4'b0000) begin n_fail++; $display("FAIL reset_irq: got %b expected 0000", {mirq_a, sirq_a, mirq_b, sirq_b}); end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_main_latch;
        mwr(16'h5003);
        n_chk++; if (latch_a !== 8'h02) begin n_fail++; $display("FAIL main_set1: got %h expected 02", latch_a); end
        mwr(16'h500F);
        n_chk++; if (latch_a !== 8'h82) begin n_fail++; $display("FAIL main_set7: got %h expected 82", latch_a); end
        mwr(16'h5013);
        n_chk++; if (latch_a !== 8'h82) begin n_fail++; $display("FAIL main_miss: got %h expected 82", latch_a); end
        m_adrs = 16'h500E; m_we = 1'b1; m_vma = 1'b0;
        cyc(1);
        m_we = 1'b0;
        n_chk++; if (latch_a !== 8'h82) begin n_fail++; $display("FAIL main_novma: got %h expected 82", latch_a); end
        mwr(16'h500E);
        mwr(16'h5002);
        n_chk++; if (latch_a !== 8'h00) begin n_fail++; $display("FAIL main_clr: got %h expected 00", latch_a); end
    endtask

    task automatic test_sub_latch;
        swr(16'h2005);
        n_chk++; if (latch_a !== 8'h00) begin n_fail++; $display("FAIL sub_masked: got %h expected 00", latch_a); end
        swr(16'h2003);
        n_chk++; if (latch_a !== 8'h02) begin n_fail++; $display("FAIL sub_allowed: got %h expected 02", latch_a); end
        swr(16'h2002);
        bwr(16'h5000, 16'h2001);
        n_chk++; if (latch_a !== 8'h01) begin n_fail++; $display("FAIL same_idx_1: got %h expected 01", latch_a); end
        bwr(16'h5001, 16'h2000);
        n_chk++; if (latch_a !== 8'h00) begin n_fail++; $display("FAIL sub_wins: got %h expected 00", latch_a); end
        bwr(16'h500B, 16'h2007);
        n_chk++; if (latch_a !== 8'h28) begin n_fail++; $display("FAIL diff_idx: got %h expected 28", latch_a); end
        mwr(16'h500A);
        mwr(16'h5006);
        n_chk++; if (latch_a !== 8'h00) begin n_fail++; $display("FAIL sub_cleanup: got %h expected 00", latch_a); end
    endtask

    task automatic test_scroll;
        mwr(16'h3AB8);
        n_chk++; if (scroll_a !== 8'h57) begin n_fail++; $display("FAIL scroll_57: got %h expected 57", scroll_a); end
        swr(16'h3AB8);
        n_chk++; if (scroll_a !== 8'h57) begin n_fail++; $display("FAIL scroll_sub: got %h expected 57", scroll_a); end
        mwr(16'h3FF8);
        n_chk++; if (scroll_a !== 8'hFF) begin n_fail++; $display("FAIL scroll_ff: got %h expected ff", scroll_a); end
        mwr(16'h3800);
        n_chk++; if (scroll_a !== 8'h00) begin n_fail++; $display("FAIL scroll_00: got %h expected 00", scroll_a); end
    endtask

    task automatic test_irq_main;
        mwr(16'h5003);
        vblank = 1'b1;
        cyc(1);
        n_chk++; if ({mirq_a, mirq_b} !== 2'b00) begin n_fail++; $display("FAIL irq_cyc1: got %b expected 00", {mirq_a, mirq_b}); end
        cyc(1);
        n_chk++; if ({mirq_a, mirq_b} !== 2'b10) begin n_fail++; $display("FAIL irq_cyc2: got %b expected 10", {mirq_a, mirq_b}); end
        cyc(1);
        n_chk++; if (mirq_b !== 1'b1) begin n_fail++; $display("FAIL irq_lat_cyc3: got %b expected 1", mirq_b); end
        n_chk++; if ({sirq_a, sirq_b} !== 2'b00) begin n_fail++; $display("FAIL irq_sub_off: got %b expected 00", {sirq_a, sirq_b}); end
        vblank = 1'b0;
        cyc(3);
        n_chk++; if ({mirq_a, mirq_b} !== 2'b01) begin n_fail++; $display("FAIL irq_vb_fall: got %b expected 01", {mirq_a, mirq_b}); end
        mwr(16'h5002);
        n_chk++; if (mirq_b !== 1'b0) begin n_fail++; $display("FAIL irq_disable: got %b expected 0", mirq_b); end
    endtask

    task automatic test_irq_race;
        mwr(16'h5003);
        vblank = 1'b1;
        cyc(2);
        m_adrs = 16'h5002; m_vma = 1'b1; m_we = 1'b1;
        cyc(1);
        m_vma = 1'b0; m_we = 1'b0;
        n_chk++; if (mirq_b !== 1'b0 || latch_b !== 8'h00) begin n_fail++; $display("FAIL race_clr: irq %b latch %h expected 0/00", mirq_b, latch_b); end
        cyc(2);
        n_chk++; if (mirq_b !== 1'b0) begin n_fail++; $display("FAIL race_hold: got %b expected 0", mirq_b); end
        mwr(16'h5003);
        n_chk++; if ({mirq_a, mirq_b} !== 2'b10) begin n_fail++; $display("FAIL reenable_lost: got %b expected 10", {mirq_a, mirq_b}); end
        vblank = 1'b0;
        cyc(3);
        mwr(16'h5002);
    endtask

    task automatic test_irq_sub;
        swr(16'h2001);
        vblank = 1'b1;
        cyc(2);
        n_chk++; if ({sirq_a, sirq_b} !== 2'b10) begin n_fail++; $display("FAIL sirq_cyc2: got %b expected 10", {sirq_a, sirq_b}); end
        cyc(1);
        n_chk++; if (sirq_b !== 1'b1) begin n_fail++; $display("FAIL sirq_cyc3: got %b expected 1", sirq_b); end
        vblank = 1'b0;
        cyc(3);
        n_chk++; if ({sirq_a, sirq_b} !== 2'b01) begin n_fail++; $display("FAIL sirq_fall: got %b expected 01", {sirq_a, sirq_b}); end
        swr(16'h2000);
        n_chk++; if (sirq_b !== 1'b0) begin n_fail++; $display("FAIL sirq_clr: got %b expected 0", sirq_b); end
    endtask

    task automatic test_reset_async;
        mwr(16'h3AB8);
        mwr(16'h5003);
        vblank = 1'b1;
        cyc(3);
        n_chk++; if (mirq_b !== 1'b1 || scroll_b !== 8'h57) begin n_fail++; $display("FAIL pre_reset: irq %b scroll %h expected 1/57", mirq_b, scroll_b); end
        #3;
        rst = 1'b1;
        #1;
        n_chk++; if ({latch_a, latch_b} !== 16'h0000) begin n_fail++; $display("FAIL async_latch: got %h expected 0000", {latch_a, latch_b}); end
        n_chk++; if ({scroll_a, scroll_b} !== 16'h0000) begin n_fail++; $display("FAIL async_scroll: got %h expected 0000", {scroll_a, scroll_b}); end
        n_chk++; if ({mirq_a, sirq_a, mirq_b, sirq_b} !== 4'b0000) begin n_fail++; $display("FAIL async_irq: got %b expected 0000", {mirq_a, sirq_a, mirq_b, sirq_b}); end
`ifdef NAMCO_CTRL_REGS_WDOG_EN
        n_chk++; if (wdog_a !== 1'b0) begin n_fail++; $display("FAIL async_wdog: got %b expected 0", wdog_a); end
`endif
        vblank = 1'b0;
        m_adrs = 16'h5003; m_vma = 1'b1; m_we = 1'b1;
        cyc(2);
        n_chk++; if (latch_a !== 8'h00) begin n_fail++; $display("FAIL write_in_reset: got %h expected 00", latch_a); end
        rst = 1'b0;
        cyc(1);
        m_vma = 1'b0; m_we = 1'b0;
        n_chk++; if (latch_a !== 8'h02) begin n_fail++; $display("FAIL first_write: got %h expected 02", latch_a); end
        mwr(16'h5002);
    endtask

`ifdef NAMCO_CTRL_REGS_WDOG_EN
    task automatic vb_pulses(input int n);
        for (int p = 0; p < n; p++) begin
            vblank = 1'b1;
            cyc(4);
            vblank = 1'b0;
            cyc(4);
        end
    endtask

    task automatic test_wdog;
        wd_hi = 0;
        vb_pulses(8);
        cyc(30);
        n_chk++; if (wd_hi !== 16 || wdog_a !== 1'b0) begin n_fail++; $display("FAIL wdog_pulse: high %0d cycles, now %b, expected 16 and 0", wd_hi, wdog_a); end
        wd_hi = 0;
        vb_pulses(7);
        mwr(16'h8000);
        vb_pulses(2);
        cyc(30);
        n_chk++; if (wd_hi !== 0) begin n_fail++; $display("FAIL wdog_kick: high %0d cycles expected 0", wd_hi); end
        vb_pulses(6);
        mwr(16'h8000);
        cyc(30);
        n_chk++; if (wd_hi !== 16) begin n_fail++; $display("FAIL wdog_kick_in_pulse: high %0d cycles expected 16", wd_hi); end
    endtask
`endif

    initial begin
        test_reset();
        test_main_latch();
        test_sub_latch();
        test_scroll();
        test_irq_main();
        test_irq_race();
        test_irq_sub();
        test_reset_async();
`ifdef NAMCO_CTRL_REGS_WDOG_EN
        test_wdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
